// File: rtl/cla_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_add_ctrl
//   Wide adder sequencer. One 4-bit carry-look-ahead slice (cla_Adder) is
//   time-multiplexed across NIBBLES slices, least-significant nibble first.
//   The carry is registered between slices. Operands come in and the result
//   goes out over valid/ready handshakes.
//
//   Parameter : NIBBLES (2..16), operand width W = 4*NIBBLES
//   Ports     : clk, rst (sync, active-high)
//               in_valid/in_ready, a[W], b[W], cin   -- operation request
//               out_valid/out_ready, sum[W], cout    -- result
//               ovf                                  -- only with CLA_OVF_FLAG_EN
//   Macro     : CLA_OVF_FLAG_EN adds the signed-overflow flag output ovf.
// ---------------------------------------------------------------------------

// 4-bit carry-look-ahead slice: all carries computed in parallel from g/p.
module cla_Adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g    = A & B;
    assign w_p    = A ^ B;
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);
    assign S      = w_p ^ w_c[3:0];
    assign Cout   = w_c[4];
endmodule

module cla_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
`ifdef CLA_OVF_FLAG_EN
    ,
    output logic                 ovf
`endif
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             w_accept;
    logic             w_last;
    logic [IDX_W+1:0] w_lo;      // bit offset of the active nibble
    logic [3:0]       w_s;
    logic             w_co;
`ifdef CLA_OVF_FLAG_EN
    logic             r_ovf;
`endif

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST);
    assign w_lo      = {r_idx, 2'b00};
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef CLA_OVF_FLAG_EN
    assign ovf       = r_ovf;
`endif

    cla_Adder u_cla (
        .A    (r_a[w_lo +: 4]),
        .B    (r_b[w_lo +: 4]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_carry <= cin;
                    r_idx   <= '0;
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
                    r_ovf   <= 1'b0;
`endif
                end
                RUN: begin
                    r_sum[w_lo +: 4] <= w_s;
                    r_carry          <= w_co;
                    if (w_last) begin
                        r_cout <= w_co;
`ifdef CLA_OVF_FLAG_EN
                        // operands share a sign but the result sign differs
                        r_ovf  <= (r_a[W-1] ~^ r_b[W-1]) & (w_s[3] ^ r_a[W-1]);
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;  // DONE: result held until released
            endcase
        end
    end
endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
- Sequencer that performs wide (4*NIBBLES-bit) additions by time-multiplexing one 4-bit cla_Adder instance, least-significant nibble first.
- Carry is registered between nibbles.
- Operands are accepted, and results returned, over valid/ready handshakes.
- Sits between a requester (e.g. ALU or accumulator logic) and the shared 4-bit carry-look-ahead datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  requester presents a, b, cin
- in_ready  output  1  controller can accept an operation
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in of the wide add
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  wide sum
- cout  output  1  carry-out of the most significant nibble

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
- Reset state:
  - state = IDLE
  - idx = 0
  - a_reg, b_reg, sum = 0
  - carry_reg = 0, cout = 0
  - out_valid = 0
- in_ready = (state == IDLE) && !rst. It is combinational and therefore 0 during any cycle with rst high.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On in_valid && in_ready: capture a->a_reg, b->b_reg, cin->carry_reg; idx <= 0; sum <= 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - cla_Adder inputs are A = a_reg[4*idx +: 4], B = b_reg[4*idx +: 4], Cin = carry_reg.
  - Each edge: sum[4*idx +: 4] <= S; carry_reg <= Cout.
  - If idx == NIBBLES-1: cout <= Cout and go to DONE. Otherwise idx <= idx+1.
  - in_valid is ignored in RUN; no capture, no effect on the operation.
- DONE:
  - out_valid = 1 (registered, high for the whole state).
  - sum and cout are held stable until the handshake completes.
  - On out_ready: go to IDLE. out_valid is 0 from the next cycle, and in_ready is 1 from the next cycle.
  - No same-cycle result-release-and-accept: the minimum spacing between accepts is NIBBLES+2 cycles.
- Latency: accept at edge k; out_valid is high after edge k+NIBBLES.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(W+1). No truncation beyond W+1 bits.
- Outside DONE, the adder inputs may toggle freely; sum and cout are don't-care to consumers while out_valid = 0.
- Boundary conditions:
  - Reset asserted during RUN or DONE aborts the operation: no out_valid pulse, and all registers return to reset values on that edge.
  - If out_ready is held high before DONE, the release happens on the first DONE cycle, so out_valid is high for exactly one cycle.
  - If in_valid and rst are high together, reset wins and nothing is captured.
  - The idx counter is ceil(log2(NIBBLES)) bits wide and never wraps in normal operation; it is cleared on every accept.

Optional Feature:
- Macro name: CLA_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of the wide add.
  - ovf = carry into MSB XOR carry out of MSB, computed on the last RUN cycle as (a_reg[W-1] ~^ b_reg[W-1]) & (S[3] ^ a_reg[W-1]).
  - Registered alongside cout and held through DONE.
  - Reset value 0; cleared on accept.
- When not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: a=0x00FF, b=0x0001; out_ready held low 5 cycles into DONE -> out_valid and sum=0x0100 stable throughout; in_ready=0; a new in_valid is ignored until 1 cycle after out_ready.
- Reset mid-op: accept a=0x8888, b=0x8888, assert rst at idx=2 -> no out_valid; next cycle in_ready=1; subsequent add 0x0001+0x0002 gives sum=0x0003, cout=0.
- in_valid held high continuously with out_ready=1 -> accepts spaced exactly 6 cycles apart; each result matches its operands.
- With CLA_OVF_FLAG_EN defined:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.
  - 0x1234+0x0001 -> ovf=0.
